// File: rtl/vga_rx_timing.sv
// vga_rx_timing: recovers pixel coordinates from a 640x480@60 VGA stream and checks its line/frame timing.
// Ports: clk/reset (async active-low), vga_hs/vga_vs (active-low syncs), vga_blank (high = active),
// vga_r/g/b in; pix_data/pix_valid/pix_x/pix_y (2-clock latency), frame_start, locked,
// h_meas/v_meas (last measured line period / frame length), err_cnt (saturating) out.
// Optional: define VGA_RX_CHECKSUM_EN to add frame_sum, the mod-2^24 sum of a frame's pixels.
module vga_rx_timing #(
  parameter int H_DISPLAY   = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_DISPLAY   = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_meas,
  output logic [9:0]  v_meas,
  output logic [7:0]  err_cnt
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [23:0] frame_sum
`endif
);
  localparam logic [10:0] HD = 11'(H_DISPLAY);
  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [9:0]  VD = 10'(V_DISPLAY);
  localparam logic [9:0]  VT = 10'(V_TOTAL);
  localparam logic [3:0]  LF = 4'(LOCK_FRAMES);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t      state_q;
  logic        hs_q, vs_q, blank_q, hs_p_q, vs_p_q, blank_p_q;
  logic [23:0] rgb_q, pix_data_q;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [10:0] hcnt_q, hcnt_d, acnt_q, acnt_d, h_meas_q, h_meas_d, period;
  logic [9:0]  vcnt_q, vcnt_d, aline_q, aline_d, v_meas_q, v_meas_d;
  logic        h_seen_q, h_seen_d, line_err_q, line_err_d;
  logic [3:0]  good_q;
  logic        locked_q;
  logic [7:0]  err_q;
  logic        hs_fall, vs_fall, act_rise, act_fall, line_bad, frame_bad;
  assign hs_fall  = hs_p_q & ~hs_q;
  assign vs_fall  = vs_p_q & ~vs_q;
  assign act_rise = ~blank_p_q & blank_q;
  assign act_fall = blank_p_q & ~blank_q;
  assign period   = &hcnt_q ? hcnt_q : hcnt_q + 11'd1;
  // Vertical-blanking lines carry no active pixels, so a zero active count is also a good line.
  assign line_bad  = hs_fall & h_seen_q & (period != HT | (acnt_q != '0 & acnt_q != HD));
  assign frame_bad = vs_fall & (line_err_q | line_bad | vcnt_q != VT | aline_q != VD);
  always_comb begin
    pix_x_d    = act_rise ? '0 : (blank_q & ~&pix_x_q) ? pix_x_q + 10'd1 : pix_x_q;
    pix_y_d    = vs_fall ? '0 : (act_fall & ~&pix_y_q) ? pix_y_q + 10'd1 : pix_y_q;
    hcnt_d     = hs_fall ? '0 : &hcnt_q ? hcnt_q : hcnt_q + 11'd1;
    acnt_d     = hs_fall ? {10'd0, blank_q} : (blank_q & ~&acnt_q) ? acnt_q + 11'd1 : acnt_q;
    h_meas_d   = hs_fall ? period : h_meas_q;
    // An hs_fall landing on the vs_fall cycle is line 1 of the new frame.
    vcnt_d     = vs_fall ? {9'd0, hs_fall} : (hs_fall & ~&vcnt_q) ? vcnt_q + 10'd1 : vcnt_q;
    v_meas_d   = vs_fall ? vcnt_q : v_meas_q;
    aline_d    = vs_fall ? '0 : (act_fall & ~&aline_q) ? aline_q + 10'd1 : aline_q;
    // The first hs_fall after leaving SEARCH only arms the period check.
    h_seen_d   = (state_q != SEARCH) & (h_seen_q | hs_fall);
    line_err_d = ~vs_fall & (line_err_q | line_bad);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_q    <= 1'b0;
      hs_p_q     <= 1'b1;
      vs_p_q     <= 1'b1;
      blank_p_q  <= 1'b0;
      rgb_q      <= '0;
      pix_data_q <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      hcnt_q     <= '0;
      acnt_q     <= '0;
      h_meas_q   <= '0;
      vcnt_q     <= '0;
      aline_q    <= '0;
      v_meas_q   <= '0;
      h_seen_q   <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      hs_q       <= vga_hs;
      vs_q       <= vga_vs;
      blank_q    <= vga_blank;
      hs_p_q     <= hs_q;
      vs_p_q     <= vs_q;
      blank_p_q  <= blank_q;
      rgb_q      <= {vga_r, vga_g, vga_b};
      pix_data_q <= rgb_q;
      pix_x_q    <= pix_x_d;
      pix_y_q    <= pix_y_d;
      hcnt_q     <= hcnt_d;
      acnt_q     <= acnt_d;
      h_meas_q   <= h_meas_d;
      vcnt_q     <= vcnt_d;
      aline_q    <= aline_d;
      v_meas_q   <= v_meas_d;
      h_seen_q   <= h_seen_d;
      line_err_q <= line_err_d;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= '0;
    end else begin
      case (state_q)
        SEARCH: if (vs_fall) begin
          state_q <= MEASURE;
          good_q  <= '0;
        end
        MEASURE: if (line_bad | frame_bad) good_q <= '0;
        else if (vs_fall) begin
          good_q <= good_q + 4'd1;
          if (good_q + 4'd1 == LF) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
          end
        end
        LOCKED: if (line_bad | frame_bad) begin
          state_q  <= SEARCH;
          locked_q <= 1'b0;
          err_q    <= err_q + {7'd0, ~&err_q};
        end
        default: state_q <= SEARCH;
      endcase
    end
  end
  assign pix_data    = pix_data_q;
  assign pix_valid   = blank_p_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = blank_p_q & pix_x_q == '0 & pix_y_q == '0;
  assign locked      = locked_q;
  assign h_meas      = h_meas_q;
  assign v_meas      = v_meas_q;
  assign err_cnt     = err_q;
`ifdef VGA_RX_CHECKSUM_EN
  logic [23:0] acc_q, sum_in;
  logic        last_px;
  assign sum_in  = acc_q + (blank_p_q ? pix_data_q : 24'd0);
  assign last_px = blank_p_q & pix_x_q == 10'(H_DISPLAY - 1) & pix_y_q == 10'(V_DISPLAY - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q     <= '0;
      frame_sum <= '0;
    end else begin
      acc_q     <= last_px ? '0 : sum_in;
      frame_sum <= last_px ? sum_in : frame_sum;
    end
  end
`endif
endmodule
